// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the five-stage MIPS pipeline: load-use stall
// detection, bubble insertion on stall/flush, and EX operand forwarding.
module id_ex_stage (
   input  logic        clk,
   input  logic        rst,
   input  logic        id_valid,
   input  logic [4:0]  id_rs,
   input  logic [4:0]  id_rt,
   input  logic [4:0]  id_rd,
   input  logic [31:0] id_read_data1,
   input  logic [31:0] id_read_data2,
   input  logic [31:0] id_imm,
   input  logic        id_reg_write,
   input  logic        id_mem_read,
   input  logic        id_mem_write,
   input  logic        id_mem_to_reg,
   input  logic        id_alu_src,
   input  logic        id_reg_dst,
   input  logic [3:0]  id_alu_op,
   input  logic        flush,
   input  logic        exmem_reg_write,
   input  logic [4:0]  exmem_rd,
   input  logic [31:0] exmem_alu_result,
   input  logic        memwb_reg_write,
   input  logic [4:0]  memwb_rd,
   input  logic [31:0] memwb_write_data,
   output logic        stall,
   output logic        ex_valid,
   output logic [4:0]  ex_rs,
   output logic [4:0]  ex_rt,
   output logic [4:0]  ex_dest,
   output logic [31:0] ex_imm,
   output logic        ex_reg_write,
   output logic        ex_mem_read,
   output logic        ex_mem_write,
   output logic        ex_mem_to_reg,
   output logic [3:0]  ex_alu_op,
   output logic [1:0]  fwd_sel_a,
   output logic [1:0]  fwd_sel_b,
   output logic [31:0] ex_operand_a,
   output logic [31:0] ex_store_data,
   output logic [31:0] ex_alu_b
);

   logic [31:0] exRdata1;
   logic [31:0] exRdata2;
   logic        exAluSrc;
   logic        loadUseHazard;
   logic        capture;
   logic        idLive;

   // A load in EX whose destination feeds decode cannot be forwarded in time.
   assign loadUseHazard = ex_valid & ex_mem_read & (ex_dest != 5'd0) &
                          ((ex_dest == id_rs) | (ex_dest == id_rt));
   assign stall   = id_valid & loadUseHazard & ~flush;
   assign capture = ~flush & ~stall;
   assign idLive  = capture & id_valid;

   // A bubble is simply capture = 0: every field collapses to zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_valid      <= 1'b0;
         ex_rs         <= 5'd0;
         ex_rt         <= 5'd0;
         ex_dest       <= 5'd0;
         ex_imm        <= 32'd0;
         exRdata1      <= 32'd0;
         exRdata2      <= 32'd0;
         ex_reg_write  <= 1'b0;
         ex_mem_read   <= 1'b0;
         ex_mem_write  <= 1'b0;
         ex_mem_to_reg <= 1'b0;
         exAluSrc      <= 1'b0;
         ex_alu_op     <= 4'd0;
      end else begin
         ex_valid      <= idLive;
         ex_rs         <= capture ? id_rs : 5'd0;
         ex_rt         <= capture ? id_rt : 5'd0;
         ex_dest       <= capture ? (id_reg_dst ? id_rd : id_rt) : 5'd0;
         ex_imm        <= capture ? id_imm : 32'd0;
         exRdata1      <= capture ? id_read_data1 : 32'd0;
         exRdata2      <= capture ? id_read_data2 : 32'd0;
         ex_reg_write  <= idLive & id_reg_write;
         ex_mem_read   <= idLive & id_mem_read;
         ex_mem_write  <= idLive & id_mem_write;
         ex_mem_to_reg <= idLive & id_mem_to_reg;
         exAluSrc      <= idLive & id_alu_src;
         ex_alu_op     <= idLive ? id_alu_op : 4'd0;
      end
   end

   // EX/MEM is the younger producer, so it takes priority over MEM/WB.
   always_comb begin
      fwd_sel_a    = 2'b00;
      ex_operand_a = exRdata1;
      if (exmem_reg_write && (exmem_rd != 5'd0) && (exmem_rd == ex_rs)) begin
         fwd_sel_a    = 2'b10;
         ex_operand_a = exmem_alu_result;
      end else if (memwb_reg_write && (memwb_rd != 5'd0) && (memwb_rd == ex_rs)) begin
         fwd_sel_a    = 2'b01;
         ex_operand_a = memwb_write_data;
      end
   end

   always_comb begin
      fwd_sel_b     = 2'b00;
      ex_store_data = exRdata2;
      if (exmem_reg_write && (exmem_rd != 5'd0) && (exmem_rd == ex_rt)) begin
         fwd_sel_b     = 2'b10;
         ex_store_data = exmem_alu_result;
      end else if (memwb_reg_write && (memwb_rd != 5'd0) && (memwb_rd == ex_rt)) begin
         fwd_sel_b     = 2'b01;
         ex_store_data = memwb_write_data;
      end
   end

   assign ex_alu_b = exAluSrc ? ex_imm : ex_store_data;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: per-scenario tasks with an expected
// queue filled at drive time and drained when outputs are sampled.
module tb_id_ex_stage;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        id_valid;
   logic [4:0]  id_rs, id_rt, id_rd;
   logic [31:0] id_read_data1, id_read_data2, id_imm;
   logic        id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src, id_reg_dst;
   logic [3:0]  id_alu_op;
   logic        flush;
   logic        exmem_reg_write;
   logic [4:0]  exmem_rd;
   logic [31:0] exmem_alu_result;
   logic        memwb_reg_write;
   logic [4:0]  memwb_rd;
   logic [31:0] memwb_write_data;
   logic        stall, ex_valid;
   logic [4:0]  ex_rs, ex_rt, ex_dest;
   logic [31:0] ex_imm;
   logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
   logic [3:0]  ex_alu_op;
   logic [1:0]  fwd_sel_a, fwd_sel_b;
   logic [31:0] ex_operand_a, ex_store_data, ex_alu_b;

   logic [31:0] exp_q[$];
   int vectors = 0;
   int misses = 0;

   id_ex_stage dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
      .id_read_data1(id_read_data1), .id_read_data2(id_read_data2), .id_imm(id_imm),
      .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
      .id_mem_to_reg(id_mem_to_reg), .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst),
      .id_alu_op(id_alu_op), .flush(flush), .exmem_reg_write(exmem_reg_write),
      .exmem_rd(exmem_rd), .exmem_alu_result(exmem_alu_result),
      .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_write_data(memwb_write_data),
      .stall(stall), .ex_valid(ex_valid), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_dest(ex_dest),
      .ex_imm(ex_imm), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
      .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg), .ex_alu_op(ex_alu_op),
      .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b), .ex_operand_a(ex_operand_a),
      .ex_store_data(ex_store_data), .ex_alu_b(ex_alu_b)
   );

   // clock
   always #5 clk = ~clk;

   // ---------------- driver tasks ----------------
   task automatic drive_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                           input logic [4:0] rd, input logic [31:0] d1, input logic [31:0] d2,
                           input logic [31:0] imm, input logic rw, input logic mr,
                           input logic mw, input logic m2r, input logic asrc,
                           input logic rdst, input logic [3:0] op);
      id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd;
      id_read_data1 = d1; id_read_data2 = d2; id_imm = imm;
      id_reg_write = rw; id_mem_read = mr; id_mem_write = mw;
      id_mem_to_reg = m2r; id_alu_src = asrc; id_reg_dst = rdst; id_alu_op = op;
   endtask

   task automatic set_fwd(input logic ew, input logic [4:0] erd, input logic [31:0] eres,
                          input logic ww, input logic [4:0] wrd, input logic [31:0] wdat);
      exmem_reg_write = ew; exmem_rd = erd; exmem_alu_result = eres;
      memwb_reg_write = ww; memwb_rd = wrd; memwb_write_data = wdat;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle;
      drive_id(1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
      set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      flush = 1'b0;
      tick;
      tick;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset;
      logic [31:0] want;
      idle;
      rst = 1'b1;
      #2;
      exp_q.push_back(32'd0); exp_q.push_back(32'd0);
      want = exp_q.pop_front(); vectors++;
      if (32'(ex_valid) !== want) begin misses++; $display("FAIL reset_valid got %h want %h", ex_valid, want); end
      want = exp_q.pop_front(); vectors++;
      if (32'(stall) !== want) begin misses++; $display("FAIL reset_stall got %h want %h", stall, want); end
      @(negedge clk);
      rst = 1'b0;
      tick;
      // lw $8 into EX, then a dependent instruction in decode
      drive_id(1'b1, 5'd2, 5'd8, 5'd0, 32'h10, 32'h20, 32'h4, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'h1);
      tick;
      drive_id(1'b1, 5'd8, 5'd3, 5'd9, 32'h30, 32'h40, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h2);
      exp_q.push_back(32'd1); exp_q.push_back(32'd1);
      #1;
      want = exp_q.pop_front(); vectors++;
      if (32'(ex_valid) !== want) begin misses++; $display("FAIL prereset_valid got %h want %h", ex_valid, want); end
      want = exp_q.pop_front(); vectors++;
      if (32'(stall) !== want) begin misses++; $display("FAIL prereset_stall got %h want %h", stall, want); end
      #2;
      rst = 1'b1;
      repeat (6) exp_q.push_back(32'd0);
      #1;
      want = exp_q.pop_front(); vectors++;
      if (32'(ex_valid) !== want) begin misses++; $display("FAIL midreset_valid got %h want %h", ex_valid, want); end
      want = exp_q.pop_front(); vectors++;
      if (32'(ex_reg_write) !== want) begin misses++; $display("FAIL midreset_regwrite got %h want %h", ex_reg_write, want); end
      want = exp_q.pop_front(); vectors++;
      if (32'(ex_mem_read) !== want) begin misses++; $display("FAIL midreset_memread got %h want %h", ex_mem_read, want); end
      want = exp_q.pop_front(); vectors++;
      if (ex_operand_a !== want) begin misses++; $display("FAIL midreset_opa got %h want %h", ex_operand_a, want); end
      want = exp_q.pop_front(); vectors++;
      if (32'(ex_dest) !== want) begin misses++; $display("FAIL midreset_dest got %h want %h", ex_dest, want); end
      want = exp_q.pop_front(); vectors++;
      if (32'(stall) !== want) begin misses++; $display("FAIL midreset_stall got %h want %h", stall, want); end
      #3;
      rst = 1'b0;
      idle;
   endtask

   task automatic test_alu_chain;
      logic [31:0] want;
      drive_id(1'b1, 5'd3, 5'd4, 5'd7, 32'h11, 32'h22, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h2);
      exp_q.push_back(32'd2); exp_q.push_back(32'h55); exp_q.push_back(32'd0);
      exp_q.push_back(32'h22); exp_q.push_back(32'd7); exp_q.push_back(32'd2); exp_q.push_back(32'h22);
      tick;
      set_fwd(1'b1, 5'd3, 32'h55, 1'b0, 5'd0, 32'd0);
      #1;
      want = exp_q.pop_front(); vectors++;
      if (32'(fwd_sel_a) !== want) begin misses++; $display("FAIL chain_sel_a got %h want %h", fwd_sel_a, want); end
      want = exp_q.pop_front(); vectors++;
      if (ex_operand_a !== want) begin misses++; $display("FAIL chain_opa got %h want %h", ex_operand_a, want); end
      want = exp_q.pop_front(); vectors++;
      if (32'(fwd_sel_b) !== want) begin misses++; $display("FAIL chain_sel_b got %h want %h", fwd_sel_b, want); end
      want = exp_q.pop_front(); vectors++;
      if (ex_store_data !== want) begin misses++; $display("FAIL chain_store got %h want %h", ex_store_data, want); end
      want = exp_q.pop_front(); vectors++;
      if (32'(ex_dest) !== want) begin misses++; $display("FAIL chain_dest got %h want %h", ex_dest, want); end
      want = exp_q.pop_front(); vectors++;
      if (32'(ex_alu_op) !== want) begin misses++; $display("FAIL chain_aluop got %h want %h", ex_alu_op, want); end
      want = exp_q.pop_front(); vectors++;
      if (ex_alu_b !== want) begin misses++; $display("FAIL chain_alub got %h want %h", ex_alu_b, want); end
      idle;
   endtask

   task automatic test_double_match;
      logic [31:0] want;
      drive_id(1'b1, 5'd1, 5'd5, 5'd6, 32'h100, 32'h200, 32'h4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'h0);
      exp_q.push_back(32'd2); exp_q.push_back(32'hA); exp_q.push_back(32'h4);
      exp_q.push_back(32'd5); exp_q.push_back(32'h100);
      exp_q.push_back(32'd1); exp_q.push_back(32'hB);
      tick;
      set_fwd(1'b1, 5'd5, 32'hA, 1'b1, 5'd5, 32'hB);
      #1;
      want = exp_q.pop_front(); vectors++;
      if (32'(fwd_sel_b) !== want) begin misses++; $display("FAIL dbl_sel_b got %h want %h", fwd_sel_b, want); end
      want = exp_q.pop_front(); vectors++;
      if (ex_store_data !== want) begin misses++; $display("FAIL dbl_store got %h want %h", ex_store_data, want); end
      want = exp_q.pop_front(); vectors++;
      if (ex_alu_b !== want) begin misses++; $display("FAIL dbl_alub got %h want %h", ex_alu_b, want); end
      want = exp_q.pop_front(); vectors++;
      if (32'(ex_dest) !== want) begin misses++; $display("FAIL dbl_dest got %h want %h", ex_dest, want); end
      want = exp_q.pop_front(); vectors++;
      if (ex_operand_a !== want) begin misses++; $display("FAIL dbl_opa got %h want %h", ex_operand_a, want); end
      set_fwd(1'b0, 5'd5, 32'hA, 1'b1, 5'd5, 32'hB);
      #1;
      want = exp_q.pop_front(); vectors++;
      if (32'(fwd_sel_b) !== want) begin misses++; $display("FAIL wb_sel_b got %h want %h", fwd_sel_b, want); end
      want = exp_q.pop_front(); vectors++;
      if (ex_store_data !== want) begin misses++; $display("FAIL wb_store got %h want %h", ex_store_data, want); end
      idle;
   endtask

   task automatic test_load_use;
      logic [31:0] want;
      drive_id(1'b1, 5'd2, 5'd8, 5'd0, 32'h10, 32'h20, 32'h4, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'h1);
      tick;
      drive_id(1'b1, 5'd9, 5'd8, 5'd10, 32'h99, 32'h77, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h2);
      exp_q.push_back(32'd1);
      exp_q.push_back(32'd0); exp_q.push_back(32'd0); exp_q.push_back(32'd0); exp_q.push_back(32'd0);
      exp_q.push_back(32'd1); exp_q.push_back(32'd1); exp_q.push_back(32'hDEAD);
      exp_q.push_back(32'd10); exp_q.push_back(32'd0);
      #1;
      want = exp_q.pop_front(); vectors++;
      if (32'(stall) !== want) begin misses++; $display("FAIL lu_stall got %h want %h", stall, want); end
      tick;
      want = exp_q.pop_front(); vectors++;
      if (32'(ex_valid) !== want) begin misses++; $display("FAIL lu_bubble_valid got %h want %h", ex_valid, want); end
      want = exp_q.pop_front(); vectors++;
      if (32'(ex_reg_write) !== want) begin misses++; $display("FAIL lu_bubble_rw got %h want %h", ex_reg_write, want); end
      want = exp_q.pop_front(); vectors++;
      if (32'(ex_mem_read) !== want) begin misses++; $display("FAIL lu_bubble_mr got %h want %h", ex_mem_read, want); end
      want = exp_q.pop_front(); vectors++;
      if (32'(stall) !== want) begin misses++; $display("FAIL lu_one_stall got %h want %h", stall, want); end
      tick;
      set_fwd(1'b0, 5'd0, 32'd0, 1'b1, 5'd8, 32'hDEAD);
      #1;
      want = exp_q.pop_front(); vectors++;
      if (32'(ex_valid) !== want) begin misses++; $display("FAIL lu_capt_valid got %h want %h", ex_valid, want); end
      want = exp_q.pop_front(); vectors++;
      if (32'(fwd_sel_b) !== want) begin misses++; $display("FAIL lu_sel_b got %h want %h", fwd_sel_b, want); end
      want = exp_q.pop_front(); vectors++;
      if (ex_store_data !== want) begin misses++; $display("FAIL lu_store got %h want %h", ex_store_data, want); end
      want = exp_q.pop_front(); vectors++;
      if (32'(ex_dest) !== want) begin misses++; $display("FAIL lu_dest got %h want %h", ex_dest, want); end
      want = exp_q.pop_front(); vectors++;
      if (32'(stall) !== want) begin misses++; $display("FAIL lu_after_stall got %h want %h", stall, want); end
      idle;
   endtask

   task automatic test_zero_reg;
      logic [31:0] want;
      drive_id(1'b1, 5'd0, 5'd1, 5'd2, 32'h0, 32'h5, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h2);
      exp_q.push_back(32'd0); exp_q.push_back(32'd0); exp_q.push_back(32'd1); exp_q.push_back(32'd0);
      tick;
      set_fwd(1'b1, 5'd0, 32'hBAD, 1'b1, 5'd0, 32'hBAD);
      #1;
      want = exp_q.pop_front(); vectors++;
      if (32'(fwd_sel_a) !== want) begin misses++; $display("FAIL zero_sel_a got %h want %h", fwd_sel_a, want); end
      want = exp_q.pop_front(); vectors++;
      if (ex_operand_a !== want) begin misses++; $display("FAIL zero_opa got %h want %h", ex_operand_a, want); end
      set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      drive_id(1'b1, 5'd4, 5'd0, 5'd0, 32'h0, 32'h0, 32'h8, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'h1);
      tick;
      drive_id(1'b1, 5'd0, 5'd0, 5'd3, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h2);
      #1;
      want = exp_q.pop_front(); vectors++;
      if (32'(ex_mem_read) !== want) begin misses++; $display("FAIL zero_lw_in_ex got %h want %h", ex_mem_read, want); end
      want = exp_q.pop_front(); vectors++;
      if (32'(stall) !== want) begin misses++; $display("FAIL zero_stall got %h want %h", stall, want); end
      idle;
   endtask

   task automatic test_flush;
      logic [31:0] want;
      drive_id(1'b1, 5'd2, 5'd8, 5'd0, 32'h10, 32'h20, 32'h4, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'h1);
      tick;
      drive_id(1'b1, 5'd8, 5'd8, 5'd11, 32'h1, 32'h2, 32'h3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'h7);
      flush = 1'b1;
      repeat (6) exp_q.push_back(32'd0);
      #1;
      want = exp_q.pop_front(); vectors++;
      if (32'(stall) !== want) begin misses++; $display("FAIL flush_stall got %h want %h", stall, want); end
      tick;
      want = exp_q.pop_front(); vectors++;
      if (32'(ex_valid) !== want) begin misses++; $display("FAIL flush_valid got %h want %h", ex_valid, want); end
      want = exp_q.pop_front(); vectors++;
      if (32'(ex_reg_write) !== want) begin misses++; $display("FAIL flush_rw got %h want %h", ex_reg_write, want); end
      want = exp_q.pop_front(); vectors++;
      if (32'(ex_mem_write) !== want) begin misses++; $display("FAIL flush_mw got %h want %h", ex_mem_write, want); end
      want = exp_q.pop_front(); vectors++;
      if (32'(ex_mem_to_reg) !== want) begin misses++; $display("FAIL flush_m2r got %h want %h", ex_mem_to_reg, want); end
      want = exp_q.pop_front(); vectors++;
      if (32'(ex_alu_op) !== want) begin misses++; $display("FAIL flush_aluop got %h want %h", ex_alu_op, want); end
      idle;
   endtask

   task automatic test_invalid;
      logic [31:0] want;
      drive_id(1'b0, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 32'hCAFE, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'hF);
      exp_q.push_back(32'd0); exp_q.push_back(32'd0); exp_q.push_back(32'd0);
      exp_q.push_back(32'd0); exp_q.push_back(32'hCAFE);
      tick;
      want = exp_q.pop_front(); vectors++;
      if (32'(ex_valid) !== want) begin misses++; $display("FAIL inv_valid got %h want %h", ex_valid, want); end
      want = exp_q.pop_front(); vectors++;
      if (32'(ex_reg_write) !== want) begin misses++; $display("FAIL inv_rw got %h want %h", ex_reg_write, want); end
      want = exp_q.pop_front(); vectors++;
      if (32'(ex_mem_read) !== want) begin misses++; $display("FAIL inv_mr got %h want %h", ex_mem_read, want); end
      want = exp_q.pop_front(); vectors++;
      if (32'(ex_alu_op) !== want) begin misses++; $display("FAIL inv_aluop got %h want %h", ex_alu_op, want); end
      want = exp_q.pop_front(); vectors++;
      if (ex_imm !== want) begin misses++; $display("FAIL inv_imm got %h want %h", ex_imm, want); end
      idle;
   endtask

   task automatic test_back_to_back;
      logic [31:0] want;
      logic v, rw, mw, m2r, asrc, rdst;
      logic [4:0] rs, rt, rd, dest;
      logic [31:0] d1, imm;
      logic [3:0] op;
      for (int i = 0; i < 20; i++) begin
         v = 1'($urandom_range(0, 1)); rw = 1'($urandom_range(0, 1));
         mw = 1'($urandom_range(0, 1)); m2r = 1'($urandom_range(0, 1));
         asrc = 1'($urandom_range(0, 1)); rdst = 1'($urandom_range(0, 1));
         rs = 5'($urandom_range(0, 31)); rt = 5'($urandom_range(0, 31)); rd = 5'($urandom_range(0, 31));
         d1 = $urandom; imm = $urandom; op = 4'($urandom_range(0, 15));
         drive_id(v, rs, rt, rd, d1, 32'h0, imm, rw, 1'b0, mw, m2r, asrc, rdst, op);
         dest = rdst ? rd : rt;
         exp_q.push_back(imm);
         exp_q.push_back(d1);
         exp_q.push_back(32'({v, rw & v, mw & v, m2r & v, (v ? op : 4'd0), dest}));
         tick;
         want = exp_q.pop_front(); vectors++;
         if (ex_imm !== want) begin misses++; $display("FAIL b2b_imm[%0d] got %h want %h", i, ex_imm, want); end
         want = exp_q.pop_front(); vectors++;
         if (ex_operand_a !== want) begin misses++; $display("FAIL b2b_opa[%0d] got %h want %h", i, ex_operand_a, want); end
         want = exp_q.pop_front(); vectors++;
         if (32'({ex_valid, ex_reg_write, ex_mem_write, ex_mem_to_reg, ex_alu_op, ex_dest}) !== want) begin
            misses++;
            $display("FAIL b2b_ctrl[%0d] got %h want %h", i,
                     32'({ex_valid, ex_reg_write, ex_mem_write, ex_mem_to_reg, ex_alu_op, ex_dest}), want);
         end
      end
      idle;
   endtask

   initial begin
      test_reset;
      test_alu_chain;
      test_double_match;
      test_load_use;
      test_zero_reg;
      test_flush;
      test_invalid;
      test_back_to_back;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
      $finish;
   end

endmodule
